// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle MIPS-style datapath.
// Moore outputs decode the state; only the fetch and decode handshakes look at inputs.
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic       pc_en,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       illegal_op,
    output logic       i_or_d,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_e state_q, state_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        state_d    = state_q;
        pc_write   = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        i_or_d     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYP:      state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d    = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                branch    = 1'b1;
                pc_src    = 2'b01;
                state_d   = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase

        pc_en = pc_write | (branch & zero);

        // Reset kills every write enable immediately, so an abandoned instruction commits nothing.
        if (rst) begin
            pc_write   = 1'b0;
            branch     = 1'b0;
            pc_en      = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are listed below, clock and reset first.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 opcode  in  6  instr[31:26] from instruction register, valid from DECODE onward.
REQ-005 zero  in  1  ALU zero flag, same cycle.
REQ-006 mem_ready  in  1  memory acknowledge; a memory access completes in the cycle it is 1.
REQ-007 Write-enable outputs, each 1 bit, out: pc_write, branch, pc_en, ir_write, mem_read, mem_write, reg_write, illegal_op.
REQ-008 Mux-select outputs, out: i_or_d (1), reg_dst (1), mem_to_reg (1), alu_src_a (1).
REQ-009 alu_src_b  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-010 alu_op  out  2  00=add, 01=sub, 10=decode by funct; 11 SHALL never be driven.
REQ-011 pc_src  out  2  00=ALU result, 01=ALUOut register, 10=jump target.
REQ-012 state  out  4  current state encoding, for debug.

Function
REQ-013 The block SHALL be a Moore FSM; every output SHALL be a function of state only, except ir_write, pc_write, pc_en and illegal_op as stated below.
REQ-014 State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; 12-15 SHALL go to FETCH on the next edge.
REQ-015 Any output not listed for a state SHALL be 0 in that state.
REQ-016 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write=pc_write=mem_ready; stays in FETCH while mem_ready=0, goes to DECODE when mem_ready=1.
REQ-017 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
REQ-018 DECODE transitions by opcode: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other -> FETCH.
REQ-019 An unrecognised opcode in DECODE SHALL assert illegal_op for exactly that one cycle.
REQ-020 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; goes to MEMRD for lw and to MEMWR for sw.
REQ-021 MEMRD: mem_read=1, i_or_d=1; holds while mem_ready=0; goes to MEMWB when mem_ready=1.
REQ-022 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; goes to FETCH.
REQ-023 MEMWR: mem_write=1, i_or_d=1; holds while mem_ready=0; goes to FETCH when mem_ready=1.
REQ-024 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; goes to ALUWB.
REQ-025 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; goes to FETCH.
REQ-026 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_src=01; goes to FETCH.
REQ-027 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; goes to ADDIWB.
REQ-028 ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; goes to FETCH.
REQ-029 JUMP: pc_src=10, pc_write=1; goes to FETCH.
REQ-030 pc_en SHALL be combinational and equal pc_write | (branch & zero).
REQ-031 Instruction latencies from FETCH entry with mem_ready=1 throughout: lw 5 cycles; sw, R-type and addi 4; beq and j 3.
REQ-032 Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle; all outputs SHALL hold stable meanwhile.

Reset
REQ-033 While rst=1 at a rising edge, state SHALL become FETCH.
REQ-034 While rst=1, all write-enable outputs SHALL be forced to 0, including pc_en and illegal_op.
REQ-035 Reset asserted in any state, including mid-stall, SHALL abandon the instruction with no further write enables.
REQ-036 The first cycle after rst deasserts SHALL be FETCH with FETCH outputs.

Verification
REQ-037 lw (100011), mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-038 beq (000100) with zero=1 -> pc_en=1 in state 8 with pc_src=01; the same instruction with zero=0 -> pc_en=0 in state 8.
REQ-039 sw with mem_ready=0 for 3 cycles in MEMWR -> state 5 held 4 cycles, mem_write=1 throughout; FETCH follows.
REQ-040 opcode 111111 -> illegal_op=1 for one cycle in DECODE, next state 0, and no reg_write or mem_write.
REQ-041 R-type -> alu_op=10 in state 6; addi -> alu_op=00 with alu_src_b=10 in state 9; alu_op never 11.
REQ-042 rst pulsed during MEMRD stall -> next state 0, all write enables 0; the following fetch completes normally.
